// File: rtl/clk_switch_ctrl_if.sv
// Requester-side handshake bundle for clk_switch_ctrl.
// The master side raises level requests with a desired source; the slave
// side (the controller) answers with grant, owner and completion status.
interface clk_switch_ctrl_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] req_src;
  logic [NREQ-1:0] gnt;
  logic [2:0]      owner;
  logic            done;
  logic            err;
  logic            busy;

  modport master (
    output req,
    output req_src,
    input  gnt,
    input  owner,
    input  done,
    input  err,
    input  busy
  );

  modport slave (
    input  req,
    input  req_src,
    output gnt,
    output owner,
    output done,
    output err,
    output busy
  );
endinterface

// File: rtl/clk_switch_ctrl.sv
// Sequencer/arbiter in front of the two-source glitch-free clock mux.
// Grants one source-change request at a time (round-robin), drives the mux
// select, waits for the synchronized gate status to confirm the handover
// (with timeout), then enforces a dwell period before the next grant.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | arbitrate; no-op requests finish here with gnt+done
//   WAIT  | select driven to target; waiting for gate status or timeout
//   HOLD  | minimum dwell after a completed or failed switch
//
// Source encoding everywhere: 1 = clk0, 0 = clk1.
// Gate status: [1] = clk1 gate on, [0] = clk0 gate on.
module clk_switch_ctrl #(
  parameter int NREQ    = 4,
  parameter int DWELL   = 16,
  parameter int TIMEOUT = 64,
  parameter bit RST_SEL = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  clk_switch_ctrl_if.slave bus,
  input  logic [1:0]       src_active,
  output logic             select,
  output logic             cur_src
);

  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TMAX = (DWELL > TIMEOUT) ? DWELL : TIMEOUT;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t          state;
  logic [PW-1:0]   rr;
  logic [TW-1:0]   timer;
  logic            target;
  logic [1:0]      sync1;
  logic [1:0]      sync_act;

  logic [NREQ-1:0] gnt_r;
  logic [2:0]      owner_r;
  logic            done_r;
  logic            err_r;
  logic            busy_r;
  logic            select_r;
  logic            cur_src_r;

  logic [PW-1:0]   win;
  logic            win_vld;
  logic            win_src;
  logic [PW-1:0]   rr_next;
  logic            confirm;

  // Offset from the round-robin pointer, wrapped modulo NREQ.
  function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return PW'(s);
  endfunction

  // Round-robin search: scan downward so the smallest offset from rr wins.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (bus.req[wrap_idx(rr, i)]) begin
        win     = wrap_idx(rr, i);
        win_vld = 1'b1;
      end
    end
  end

  assign win_src = bus.req_src[win];
  assign rr_next = (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;

  // Handover is only accepted on the clean single-gate pattern; 00/11 are
  // transitional states of the mux and never count.
  assign confirm = target ? (sync_act == 2'b01) : (sync_act == 2'b10);

  // Two-flop synchronizer for the asynchronous gate-status flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1    <= 2'b00;
      sync_act <= 2'b00;
    end else begin
      sync1    <= src_active;
      sync_act <= sync1;
    end
  end

  // Main sequencer: arbitration, select drive, confirm/timeout and dwell.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr        <= '0;
      timer     <= '0;
      target    <= RST_SEL;
      gnt_r     <= '0;
      owner_r   <= '0;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
      busy_r    <= 1'b0;
      select_r  <= RST_SEL;
      cur_src_r <= RST_SEL;
    end else begin
      gnt_r  <= '0;
      done_r <= 1'b0;
      err_r  <= 1'b0;
      case (state)
        IDLE: begin
          if (win_vld) begin
            gnt_r[win] <= 1'b1;
            owner_r    <= 3'(win);
            rr         <= rr_next;
            if (win_src == cur_src_r) begin
              done_r <= 1'b1;
            end else begin
              select_r <= win_src;
              target   <= win_src;
              timer    <= '0;
              busy_r   <= 1'b1;
              state    <= WAIT;
            end
          end
        end
        WAIT: begin
          // Confirmation is checked first so it wins over a coincident timeout.
          if (confirm) begin
            done_r    <= 1'b1;
            cur_src_r <= target;
            timer     <= '0;
            state     <= HOLD;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            err_r    <= 1'b1;
            select_r <= cur_src_r;
            timer    <= '0;
            state    <= HOLD;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        HOLD: begin
          if (timer == TW'(DWELL - 1)) begin
            timer  <= '0;
            busy_r <= 1'b0;
            state  <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          timer  <= '0;
          busy_r <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.gnt   = gnt_r;
  assign bus.owner = owner_r;
  assign bus.done  = done_r;
  assign bus.err   = err_r;
  assign bus.busy  = busy_r;
  assign select    = select_r;
  assign cur_src   = cur_src_r;

endmodule

// File: tb/tb_clk_switch_ctrl.sv
// Directed bench for clk_switch_ctrl: inputs driven and outputs sampled on
// the falling edge, expected values worked out by hand from cycle timing.
module tb_clk_switch_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] src_active;
  logic       select;
  logic       cur_src;

  int n_chk  = 0;
  int n_pass = 0;

  int   n;
  int   w;
  logic t;
  logic seen;

  clk_switch_ctrl_if #(.NREQ(4)) bus ();

  clk_switch_ctrl #(
    .NREQ(4),
    .DWELL(16),
    .TIMEOUT(64),
    .RST_SEL(1'b1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .src_active(src_active),
    .select(select),
    .cur_src(cur_src)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_gnt(output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (bus.gnt == '0 && cnt < 100);
  endtask

  task automatic wait_done(output int cnt, output logic err_seen);
    cnt = 0;
    err_seen = 1'b0;
    do begin
      tick();
      cnt++;
      err_seen |= bus.err;
    end while (!bus.done && cnt < 100);
  endtask

  task automatic wait_idle();
    int cnt = 0;
    while (bus.busy && cnt < 200) begin
      tick();
      cnt++;
    end
    chk("idle_reached", {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("watchdog expired before the bench finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n       = 1'b0;
    src_active  = 2'b01;
    bus.req     = '0;
    bus.req_src = '0;
    repeat (3) tick();

    // Reset state
    chk("rst_select", select, 1);
    chk("rst_cur_src", cur_src, 1);
    chk("rst_gnt", bus.gnt, 0);
    chk("rst_owner", bus.owner, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_busy", bus.busy, 0);
    rst_n = 1'b1;
    repeat (3) tick();

    // No-op: requester 0 already on clk0
    bus.req     = 4'b0001;
    bus.req_src = 4'b0001;
    tick();
    chk("noop_gnt", bus.gnt, 4'b0001);
    chk("noop_done", bus.done, 1);
    chk("noop_owner", bus.owner, 0);
    chk("noop_select", select, 1);
    chk("noop_busy", bus.busy, 0);
    bus.req = '0;
    tick();
    chk("noop_gnt_pulse", bus.gnt, 0);
    chk("noop_done_pulse", bus.done, 0);

    // Normal switch to clk1 by requester 2 (rr = 1 now)
    bus.req     = 4'b0100;
    bus.req_src = 4'b0000;
    tick();
    chk("sw_gnt", bus.gnt, 4'b0100);
    chk("sw_select", select, 0);
    chk("sw_owner", bus.owner, 2);
    chk("sw_busy", bus.busy, 1);
    chk("sw_done_early", bus.done, 0);
    bus.req    = '0;
    src_active = 2'b00;
    repeat (3) tick();
    chk("sw_no_done_on_00", bus.done, 0);
    src_active = 2'b10;
    tick();
    chk("sw_done_lat1", bus.done, 0);
    tick();
    chk("sw_done_lat2", bus.done, 0);
    tick();
    chk("sw_done", bus.done, 1);
    chk("sw_cur_src", cur_src, 0);
    chk("sw_err", bus.err, 0);
    n = 0;
    while (bus.busy && n < 100) begin
      n++;
      tick();
    end
    chk("sw_hold_len", n, 16);

    // Round-robin from a fresh reset, alternating target sources
    rst_n      = 1'b0;
    src_active = 2'b01;
    tick();
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("rr_rst_cur_src", cur_src, 1);
    bus.req_src = 4'b1010;
    bus.req     = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      w = i % 4;
      t = (w % 2) == 1;
      wait_gnt(n);
      chk("rr_gap", n, (i == 0) ? 1 : 17);
      chk("rr_gnt", {28'd0, bus.gnt}, 32'd1 << w);
      chk("rr_owner", bus.owner, w);
      chk("rr_select", select, t);
      if (i == 5) bus.req = '0;
      src_active = 2'b00;
      tick();
      tick();
      src_active = t ? 2'b01 : 2'b10;
      wait_done(n, seen);
      chk("rr_done_lat", n, 3);
      chk("rr_no_err", seen, 0);
      chk("rr_cur_src", cur_src, t);
    end
    wait_idle();

    // Timeout: mux stuck on clk0, requester 2 asks for clk1 (rr = 2)
    bus.req_src = 4'b0000;
    bus.req     = 4'b0100;
    tick();
    chk("to_gnt", bus.gnt, 4'b0100);
    chk("to_select", select, 0);
    bus.req = '0;
    n = 0;
    seen = 1'b0;
    do begin
      tick();
      n++;
      seen |= bus.done;
    end while (!bus.err && n < 100);
    chk("to_latency", n, 64);
    chk("to_select_revert", select, 1);
    chk("to_cur_src", cur_src, 1);
    chk("to_no_done", seen, 0);
    chk("to_busy", bus.busy, 1);
    tick();
    chk("to_err_pulse", bus.err, 0);
    wait_idle();

    // Reset in WAIT; pending requests 0 and 3 (rr would be 3 without reset)
    bus.req_src = 4'b1001;
    bus.req     = 4'b0100;
    tick();
    chk("rs_gnt", bus.gnt, 4'b0100);
    bus.req = 4'b1001;
    repeat (9) tick();
    rst_n = 1'b0;
    tick();
    chk("rs_busy", bus.busy, 0);
    chk("rs_select", select, 1);
    chk("rs_cur_src", cur_src, 1);
    chk("rs_done", bus.done, 0);
    chk("rs_err", bus.err, 0);
    chk("rs_gnt_clear", bus.gnt, 0);
    rst_n = 1'b1;
    tick();
    chk("rs_rearb_gnt", bus.gnt, 4'b0001);
    chk("rs_rearb_done", bus.done, 1);
    chk("rs_rearb_owner", bus.owner, 0);
    bus.req = '0;
    repeat (3) tick();

    // Confirmation landing on the last WAIT cycle (rr = 1)
    bus.req_src = 4'b0000;
    bus.req     = 4'b0010;
    tick();
    chk("bd_gnt", bus.gnt, 4'b0010);
    bus.req = '0;
    repeat (61) tick();
    src_active = 2'b10;
    tick();
    tick();
    chk("bd_no_err_early", bus.err, 0);
    chk("bd_no_done_early", bus.done, 0);
    tick();
    chk("bd_done", bus.done, 1);
    chk("bd_err", bus.err, 0);
    chk("bd_cur_src", cur_src, 0);
    chk("bd_select", select, 0);
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/clk_switch_ctrl.md
Name: clk_switch_ctrl

Overview:
- Sequencer and arbiter in front of the two-source glitch-free clock mux.
- Collects clock-source change requests from NREQ requesters and grants one at a time, round-robin.
- Drives the mux `select` line, then waits for the mux's asynchronous gate-status flags to confirm the handover, with a timeout.
- Enforces a minimum dwell time between switches. Runs entirely in a free-running system clock domain.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DWELL, 16, cycles in HOLD after each completed or failed switch (>=1).
- TIMEOUT, 64, max cycles in WAIT before declaring failure (>=4).
- RST_SEL, 1, reset value of `select` and `cur_src` (1 = clk0, 0 = clk1).

Ports:
- clk  in  1  system clock; sole clock of the block.
- rst_n  in  1  synchronous, active-low reset, sampled on rising clk.
- req  in  NREQ  level request per requester; held high until its gnt pulse.
- req_src  in  NREQ  desired source per requester (1 = clk0, 0 = clk1); stable while req is high.
- src_active  in  2  asynchronous mux gate status: [1] = clk1 gate on, [0] = clk0 gate on.
- select  out  1  mux select, registered (1 = clk0).
- cur_src  out  1  last confirmed source.
- gnt  out  NREQ  one-hot, one-cycle grant pulse.
- owner  out  3  index of last granted requester; held until the next grant.
- done  out  1  one-cycle pulse: switch confirmed or no-op satisfied.
- err  out  1  one-cycle pulse: switch timed out.
- busy  out  1  high in WAIT and HOLD.

Behaviour:
- **Reset** (rst_n = 0 at a clk edge):
  - state = IDLE; select = cur_src = RST_SEL.
  - gnt = 0, owner = 0, done = err = busy = 0.
  - rr pointer = 0, timer = 0, synchronizer flops = 0.
  - Reset asserted in any state aborts the operation on that edge; no done/err is issued for the aborted switch.
- **Status synchronizer**: src_active passes through a 2-flop synchronizer, giving `sync_act`. Every decision uses sync_act only.
- **Arbitration** (IDLE only):
  - Search req starting at index rr and wrapping modulo NREQ; the first set bit wins.
  - rr becomes winner+1 (wraps to 0 after NREQ-1).
  - Requests arriving in WAIT/HOLD stay pending; nothing is lost because req is level.
- **FSM IDLE, no request**: stay in IDLE.
- **FSM IDLE, winner has req_src == cur_src** (no-op):
  - gnt[w] and done pulse in the same cycle; owner = w.
  - Stay in IDLE; select is unchanged.
- **FSM IDLE, winner has req_src != cur_src**:
  - gnt[w] pulses; owner = w; select <= req_src[w]; timer = 0.
  - Go to WAIT, with the target captured internally.
- **FSM WAIT**:
  - timer increments every cycle.
  - Confirmation: sync_act == 2'b01 for target 1, or 2'b10 for target 0.
  - On confirmation: done pulses, cur_src <= target, timer = 0, go to HOLD.
  - Else if timer == TIMEOUT-1: err pulses, select <= cur_src (revert), timer = 0, go to HOLD.
  - Confirmation and timeout in the same cycle: confirmation wins.
  - Intermediate values 2'b00 and 2'b11 never confirm.
- **FSM HOLD**:
  - timer increments; at timer == DWELL-1 go to IDLE.
  - The next grant is possible on the following cycle.
- **Latency**:
  - req high in IDLE -> gnt on the next clk edge (registered outputs).
  - Earliest done = 3 cycles after select changes (2-flop sync plus compare register), counted from the mux responding.
- **Outputs**:
  - gnt, done and err are never high for more than one cycle.
  - At most one gnt bit is set.
  - done and err are never set together.
- **Widths**:
  - owner is zero-extended.
  - The timer width covers max(DWELL, TIMEOUT); there is no wrap-around inside a state.

Test Plan:
- **Reset and no-op**: reset, RST_SEL = 1, sync_act = 01, req = 0001 with req_src[0] = 1 -> one cycle later gnt = 0001 and done = 1; select stays 1; state stays IDLE.
- **Normal switch**: req[2] = 1 with req_src[2] = 0; a model mux drives src_active 01 -> 00 -> 10 over 6 cycles:
  - gnt = 0100 and select = 0 on the same edge.
  - done appears 3 cycles after src_active = 10; cur_src = 0; busy stays high for 16 HOLD cycles.
- **Round-robin fairness**: req = 1111, requesters alternating sources, model mux confirms each switch -> grant order 0, 1, 2, 3, 0, 1; each grant is separated by WAIT + 16 HOLD cycles.
- **Timeout**: switch request with src_active stuck at 01 -> err pulse exactly 64 cycles after gnt; select reverts to 1; cur_src unchanged; no done.
- **Reset mid-WAIT**: assert rst_n = 0 for 1 cycle, 10 cycles after a gnt -> next cycle state = IDLE, select = RST_SEL, busy = 0, no done/err pulse; a pending req is re-arbitrated from rr = 0.
- **Confirm at timeout boundary**: sync_act matches the target exactly on cycle TIMEOUT-1 -> done = 1, err = 0, cur_src updated.
